score_display_gen: RTL and testbench
====================================

Name: score_display_gen

Overview:
Parametrised score display driver for the game board. It converts a binary score to BCD with an iterative double-dabble engine, then drives NUM_DIGITS active-low seven-segment digits. It also drives a row-scanned ROWS x COLS dot-matrix bar graph showing score progress. It sits between the game-logic score counter and the board's seven-segment and dot-matrix pins, in the clk2 scan-clock domain.

Parameters:
SCORE_W, 14, width of binary score input
NUM_DIGITS, 4, number of seven-segment digits driven (decimal max 10^NUM_DIGITS-1)
ROWS, 8, dot-matrix rows scanned
COLS, 8, dot-matrix columns; must be a power of two
BAR_SHIFT, 7, one bar dot per 2^BAR_SHIFT points

Ports:
clk2  input  1  scan/system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
score  input  SCORE_W  binary score from game logic, unsigned
seven  output  7*NUM_DIGITS  active-low segments {g..a}; digit 0 (units) at [6:0]
dot_row  output  ROWS  active-low one-hot row select
dot_col  output  COLS  active-high column data for the selected row
overflow  output  1  high while the displayed score exceeds 10^NUM_DIGITS-1
busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (asynchronous, active-low; clock clk2): seven all ones (blank), dot_row all ones, dot_col zero, overflow 0, busy 0, row_count 0, FSM state IDLE, force flag set.
- FSM states are IDLE, CONV and UPDATE.
- IDLE: when (score != last_score) or force is set, capture score into last_score, clear force, set busy, and go to CONV.
- CONV: runs exactly SCORE_W shift/add-3 cycles on a (4*NUM_DIGITS+SCORE_W)-bit shift register. The BCD width must hold SCORE_W bits; any extra decade is discarded for the overflow test. After the last cycle, go to UPDATE.
- UPDATE: one cycle. Registers the seven-segment codes, overflow and lit count, clears busy, and returns to IDLE.
- Latency: a score change sampled in IDLE at cycle N is visible on the outputs at cycle N+SCORE_W+2.
- Changes to score during CONV or UPDATE are ignored. They are picked up by the next IDLE comparison, so the display never shows a mix of two scores.
- Overflow: if last_score > 10^NUM_DIGITS-1, every digit shows 9 and overflow=1. Otherwise overflow=0.
- Segment codes (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value shows blank (1111111).
- Bar lit count: lit = min(last_score >> BAR_SHIFT, ROWS*COLS). It is latched in UPDATE and held between updates.
- Row scan: row_count increments every clk2 and wraps from ROWS-1 to 0.
- dot_row for row r has bit (ROWS-1-r) low and all other bits high.
- dot_col is registered in the same cycle as dot_row and belongs to the same row:
  - r < lit/COLS: all ones.
  - r == lit/COLS: the top (lit mod COLS) bits are ones, MSB first; the rest are zeros.
  - r > lit/COLS: zeros.
- When lit == ROWS*COLS, all rows are all ones.
- The row scan runs continuously, independent of the FSM. Only lit changes at UPDATE.
- Reset mid-conversion: all state returns to reset values immediately. After release, force causes a fresh conversion of the current score.

Optional Feature:
SCORE_LZB_EN.
- Defined: leading-zero blanking. Digits above the most significant nonzero digit show blank (1111111). Digit 0 is always shown. Overflow display (all 9s) is unaffected.
- Undefined: all NUM_DIGITS digits are always shown, with leading zeros.

Decomposition:
- Package score_pkg holds:
  - the seven-segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - the FSM state enum (IDLE, CONV, UPDATE);
  - a function seg_encode(4-bit BCD) that returns the 7-bit code.
- One sub-module, bin2bcd_seq: the iterative double-dabble engine.
  - Parameters: SCORE_W, NUM_DIGITS.
  - Interface: start/bin in; done/bcd out.
  - The top module owns the FSM, the overflow/lit logic and the row scanner.

Test Plan:
1. Reset released with score=0 -> during reset: seven=all 1s, dot_row=8'hFF, dot_col=0. At cycle 16: seven={4{1000000}}, overflow=0, dot_col=0 on every row.
2. score=1234 -> 16 cycles later seven digits 3..0 = 1111001, 0100100, 0110000, 0011001. lit=9, so row0 col=8'hFF, row1 col=8'h80, rows2-7 col=0. dot_row walks 7F,BF,...,FE,7F (wrap).
3. score=12000 -> overflow=1, all digits 0010000. lit saturates at 64, so all rows show 8'hFF.
4. score 100->200 at cycle 5 of CONV -> first update shows 0100 with busy pulse. A second conversion follows. 0200 appears 16 cycles after the next IDLE, with no intermediate value.
5. Reset asserted mid-CONV -> outputs take reset values in the same cycle. After release, a conversion restarts and the current score appears at release+16.
6. SCORE_LZB_EN defined, score=5 -> digits 3..1 = 1111111, digit0 = 0010010. With score=0, digit0 = 1000000 and the rest are blank.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants, FSM state type and helpers for the score display driver.
package score_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Decimal digits needed to hold any w-bit unsigned value.
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned m;
        int unsigned     n;
        m = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m != 0) begin
                n++;
                m = m / 64'd10;
            end
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < 20; i++) begin
            if (i < n) p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift/add-3 step per clk2, SCORE_W steps.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk2,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SCORE_W-1:0]      bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    // Internal BCD field always wide enough for SCORE_W bits; surplus decades
    // are never exported.
    localparam int unsigned NeedDigits = dec_digits(SCORE_W);
    localparam int unsigned BcdDigits  = (NeedDigits > NUM_DIGITS) ? NeedDigits : NUM_DIGITS;
    localparam int unsigned ShW        = 4 * BcdDigits + SCORE_W;
    localparam int unsigned CntW       = $clog2(SCORE_W + 1);

    logic [ShW-1:0]  sh_q, adj;
    logic [CntW-1:0] cnt_q;
    logic            run_q, done_q;

    always_comb begin
        adj = sh_q;
        for (int i = 0; i < int'(BcdDigits); i++) begin
            if (adj[SCORE_W + 4*i +: 4] >= 4'd5) begin
                adj[SCORE_W + 4*i +: 4] = adj[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            sh_q   <= {{(4*BcdDigits){1'b0}}, bin};
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            sh_q  <= adj << 1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(SCORE_W - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign bcd  = sh_q[SCORE_W +: 4*NUM_DIGITS];

endmodule

// File: rtl/score_display_gen.sv
// Score display driver: BCD seven-segment digits plus row-scanned bar graph.
// Optional build macro SCORE_LZB_EN enables leading-zero blanking.
module score_display_gen
    import score_pkg::*;
#(
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned BAR_SHIFT  = 7
) (
    input  logic                    clk2,
    input  logic                    reset,
    input  logic [SCORE_W-1:0]      score,
    output logic [7*NUM_DIGITS-1:0] seven,
    output logic [ROWS-1:0]         dot_row,
    output logic [COLS-1:0]         dot_col,
    output logic                    overflow,
    output logic                    busy
);

    localparam longint unsigned MaxShow  = pow10(NUM_DIGITS) - 64'd1;
    localparam int unsigned     Cells    = ROWS * COLS;
    localparam int unsigned     LitW     = $clog2(Cells + 1);
    localparam int unsigned     RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned     ColShift = $clog2(COLS);

    state_e                  state_q, state_d;
    logic [SCORE_W-1:0]      last_score_q;
    logic                    force_q, busy_q, overflow_q;
    logic [7*NUM_DIGITS-1:0] seven_q, seven_d;
    logic [LitW-1:0]         lit_q, lit_d;
    logic [RowW-1:0]         row_q;
    logic [ROWS-1:0]         dot_row_q, dot_row_d;
    logic [COLS-1:0]         dot_col_q, dot_col_d;
    logic                    start, update, conv_done, overflow_d;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [SCORE_W-1:0]      bar_raw;
    logic [LitW-1:0]         lit_full_rows, row_ext;
    logic [ColShift-1:0]     lit_part;

    bin2bcd_seq #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk2  (clk2),
        .reset (reset),
        .start (start),
        .bin   (score),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        update  = 1'b0;
        case (state_q)
            IDLE: begin
                if (score != last_score_q || force_q) begin
                    start   = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (conv_done) state_d = UPDATE;
            end
            UPDATE: begin
                update  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display values derived from the captured score, registered only in UPDATE.
    always_comb begin
        logic [3:0] digit;
        logic [6:0] code;
`ifdef SCORE_LZB_EN
        logic lead;
        lead = 1'b1;
`endif
        overflow_d = 64'(last_score_q) > MaxShow;
        seven_d    = '1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            digit = bcd[4*i +: 4];
            code  = seg_encode(digit);
`ifdef SCORE_LZB_EN
            if (lead && digit == 4'd0 && i != 0) code = SEG_BLANK;
            else lead = 1'b0;
`endif
            if (overflow_d) code = SEG_9;
            seven_d[7*i +: 7] = code;
        end
        bar_raw = last_score_q >> BAR_SHIFT;
        lit_d   = (32'(bar_raw) > Cells) ? LitW'(Cells) : LitW'(bar_raw);
    end

    always_comb begin
        lit_full_rows = lit_q >> ColShift;
        lit_part      = lit_q[ColShift-1:0];
        row_ext       = LitW'(row_q);
        dot_row_d     = ~(ROWS'(1) << (int'(ROWS) - 1 - int'(row_q)));
        if (row_ext < lit_full_rows)       dot_col_d = '1;
        else if (row_ext == lit_full_rows) dot_col_d = ~({COLS{1'b1}} >> lit_part);
        else                               dot_col_d = '0;
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_score_q <= '0;
            force_q      <= 1'b1;
            busy_q       <= 1'b0;
            seven_q      <= '1;
            overflow_q   <= 1'b0;
            lit_q        <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                last_score_q <= score;
                force_q      <= 1'b0;
                busy_q       <= 1'b1;
            end
            if (update) begin
                busy_q     <= 1'b0;
                seven_q    <= seven_d;
                overflow_q <= overflow_d;
                lit_q      <= lit_d;
            end
        end
    end

    // Free-running row scan, independent of the conversion FSM.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            row_q     <= '0;
            dot_row_q <= '1;
            dot_col_q <= '0;
        end else begin
            row_q     <= (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            dot_row_q <= dot_row_d;
            dot_col_q <= dot_col_d;
        end
    end

    assign seven    = seven_q;
    assign dot_row  = dot_row_q;
    assign dot_col  = dot_col_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_score_display_gen.sv
// Randomized self-checking bench for score_display_gen against an arithmetic model.
module tb_score_display_gen;

    localparam int unsigned SW   = 14;
    localparam int unsigned ND   = 4;
    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;
    localparam int unsigned BS   = 7;
    localparam int unsigned MAXV = 9999;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic               clk2  = 1'b0;
    logic               reset = 1'b1;
    logic [SW-1:0]      score = '0;
    logic [7*ND-1:0]    seven;
    logic [ROWS-1:0]    dot_row;
    logic [COLS-1:0]    dot_col;
    logic               overflow;
    logic               busy;

    always #5 clk2 = ~clk2;

    score_display_gen #(
        .SCORE_W    (SW),
        .NUM_DIGITS (ND),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .BAR_SHIFT  (BS)
    ) dut (
        .clk2     (clk2),
        .reset    (reset),
        .score    (score),
        .seven    (seven),
        .dot_row  (dot_row),
        .dot_col  (dot_col),
        .overflow (overflow),
        .busy     (busy)
    );

    int unsigned     n_total = 0;
    int unsigned     n_bad   = 0;

    // Reference model state
    int unsigned     m_last, m_cnt, m_lit, m_row;
    bit              m_force, m_busy, m_ovf;
    logic [7*ND-1:0] m_seven;
    logic [ROWS-1:0] m_dot_row;
    logic [COLS-1:0] m_dot_col;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7*ND-1:0] exp_seven(input int unsigned v);
        logic [7*ND-1:0] r;
        logic [6:0]      code;
        int unsigned     p;
        p = 1;
        for (int i = 0; i < int'(ND); i++) begin
            if (v > MAXV) code = SEG_TAB[9];
            else begin
                code = SEG_TAB[(v / p) % 10];
`ifdef SCORE_LZB_EN
                if (i > 0 && v < p) code = 7'b1111111;
`endif
            end
            r[7*i +: 7] = code;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [COLS-1:0] exp_col(input int unsigned r, input int unsigned lit);
        logic [COLS-1:0] c;
        c = '0;
        if (r < lit / COLS) c = '1;
        else if (r == lit / COLS) begin
            for (int j = 0; j < int'(lit % COLS); j++) c[COLS-1-j] = 1'b1;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_last = 0; m_cnt = 0; m_lit = 0; m_row = 0;
        m_force = 1; m_busy = 0; m_ovf = 0;
        m_seven = '1; m_dot_row = '1; m_dot_col = '0;
    endtask

    // One rising edge of clk2: scan uses the bar length held before the edge.
    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else begin
            m_dot_row = '1;
            m_dot_row[ROWS-1-m_row] = 1'b0;
            m_dot_col = exp_col(m_row, m_lit);
            m_row = (m_row + 1) % ROWS;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 0;
                    m_ovf   = m_last > MAXV;
                    m_seven = exp_seven(m_last);
                    m_lit   = ((m_last >> BS) > ROWS * COLS) ? ROWS * COLS : (m_last >> BS);
                end
            end else if (32'(score) != m_last || m_force) begin
                m_last  = 32'(score);
                m_force = 0;
                m_cnt   = SW + 2;
                m_busy  = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("seven", 64'(seven), 64'(m_seven));
        check_eq("dot_row", 64'(dot_row), 64'(m_dot_row));
        check_eq("dot_col", 64'(dot_col), 64'(m_dot_col));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk2);
        model_step();
        #2;
        check_all();
    endtask

    task automatic ticks(input int unsigned n);
        for (int i = 0; i < int'(n); i++) tick();
    endtask

    task automatic assert_reset_now();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #1;
        assert_reset_now();
        ticks(3);
        @(negedge clk2);
        reset = 1'b1;
        ticks(24);

        score = SW'(1234);
        ticks(40);

        score = SW'(12000);
        ticks(30);

        score = SW'(100);
        ticks(20);
        score = SW'(100);
        // Wait for conversion start, then change score 5 cycles into it.
        score = SW'(101);
        tick();
        score = SW'(100);
        ticks(5);
        score = SW'(200);
        ticks(45);

        score = SW'(4321);
        ticks(6);
        assert_reset_now();
        ticks(3);
        @(negedge clk2);
        reset = 1'b1;
        ticks(24);

        score = SW'(5);
        ticks(20);
        score = SW'(0);
        ticks(20);
        score = SW'(8191);
        ticks(20);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       score = SW'($urandom_range(0, 99));
                1:       score = SW'($urandom_range(0, 9999));
                2:       score = SW'($urandom_range(9990, 16383));
                default: score = SW'($urandom);
            endcase
            ticks($urandom_range(1, 40));
        end
        ticks(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
